// File: rtl/pxs_score_overlay_multi_pkg.sv
// pxs_score_overlay_multi_pkg: PixelStream field layout, update FSM states and the 8x8 digit font.
//   No ports; imported by pxs_score_overlay_multi.
//   Stream layout (26 bits): [25] HS, [24] VS, [23] Active, [22:20] RGB, [19:10] XC, [9:0] YC.
package pxs_score_overlay_multi_pkg;
    localparam int PXS_W  = 26;
    localparam int ACT_B  = 23;
    localparam int RGB_LO = 20;
    localparam int XC_LO  = 10;
    localparam int YC_LO  = 0;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CONV, ST_COMMIT} state_t;

    // Glyph ROM addressed as {digit,row,col}; row 0 is the top, col 0 the leftmost pixel.
    // Codes 10..15 are blank.
    function automatic logic glyph_bit(input logic [3:0] dig, input logic [2:0] row, input logic [2:0] col);
        logic [63:0] g;
        case (dig)
            4'd0:    g = 64'h3C666E7666663C00;
            4'd1:    g = 64'h1838181818187E00;
            4'd2:    g = 64'h3C66060C30607E00;
            4'd3:    g = 64'h3C66061C06663C00;
            4'd4:    g = 64'h0C1C3C6C7E0C0C00;
            4'd5:    g = 64'h7E607C0606663C00;
            4'd6:    g = 64'h3C607C6666663C00;
            4'd7:    g = 64'h7E060C1830303000;
            4'd8:    g = 64'h3C66663C66663C00;
            4'd9:    g = 64'h3C66663E060C3800;
            default: g = '0;
        endcase
        return g[{~row, ~col}];
    endfunction
endpackage

// File: rtl/pxs_bin2bcd.sv
// pxs_bin2bcd: iterative double-dabble binary to BCD converter.
//   clk, rst_n  clock, async active-low reset
//   start_i     begin a conversion of bin_i (ignored while busy_o)
//   bin_i       binary value
//   busy_o      conversion in progress
//   done_o      one-cycle pulse, BIN_W+1 cycles after start; bcd_o valid from here until next start
//   bcd_o       DIGITS packed BCD digits, most significant in the top nibble
//   ovf_o       value did not fit in DIGITS decimal digits (bcd_o is then meaningless)
module pxs_bin2bcd #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o
);
    localparam int          CW   = $clog2(BIN_W + 1);
    localparam logic [31:0] MAXV = 32'(10 ** DIGITS - 1);

    logic [BIN_W-1:0]    sh_q;
    logic [4*DIGITS-1:0] bcd_q, adj;
    logic [CW-1:0]       cnt_q;
    logic                busy_q, done_q, ovf_q;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_q[4*i +: 4] > 4'd4) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    // Overflow is decided up front; digits lost off the top of the short BCD register don't matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                sh_q   <= bin_i;
                bcd_q  <= '0;
                cnt_q  <= CW'(BIN_W);
                busy_q <= 1'b1;
                ovf_q  <= 32'(bin_i) > MAXV;
            end else if (busy_q) begin
                {bcd_q, sh_q} <= {adj, sh_q} << 1;
                cnt_q         <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;
endmodule

// File: rtl/pxs_score_overlay_multi.sv
// pxs_score_overlay_multi: draws NUM_SCORES decimal score fields as scaled 8x8 glyphs over a PixelStream.
//   px_clk         pixel clock
//   rst_n          async active-low reset
//   scores         binary scores, field k at [k*SCORE_W +: SCORE_W], sampled once per frame
//   RGBStr_i       incoming 26-bit PixelStream
//   RGBStr_o       PixelStream with overlay, fixed 2-cycle latency
//   score_updated  one-cycle pulse when freshly converted digits reach the display
module pxs_score_overlay_multi
    import pxs_score_overlay_multi_pkg::*;
#(
    parameter int                        NUM_SCORES  = 2,
    parameter int                        SCORE_W     = 8,
    parameter int                        DIGITS      = 3,
    parameter int                        SCALE_LOG2  = 2,
    parameter int                        DIGIT_GAP   = 4,
    parameter logic [NUM_SCORES*10-1:0]  POS_X       = {10'd448, 10'd128},
    parameter logic [NUM_SCORES*10-1:0]  POS_Y       = {10'd32, 10'd32},
    parameter logic [NUM_SCORES*3-1:0]   INK         = {3'b010, 3'b101},
    parameter bit                        BLANK_LZ    = 1'b1,
    parameter int                        VISIBLECOLS = 640,
    parameter int                        VISIBLEROWS = 480
) (
    input  logic                          px_clk,
    input  logic                          rst_n,
    input  logic [NUM_SCORES*SCORE_W-1:0] scores,
    input  logic [PXS_W-1:0]              RGBStr_i,
    output logic [PXS_W-1:0]              RGBStr_o,
    output logic                          score_updated
);
    localparam int CELL  = 8 << SCALE_LOG2;
    localparam int PITCH = CELL + DIGIT_GAP;
    localparam int BW    = 4 * DIGITS;
    localparam int IW    = NUM_SCORES > 1 ? $clog2(NUM_SCORES) : 1;

    state_t                                state_q;
    logic [IW-1:0]                         idx_q;
    logic                                  start_q, upd_q;
    logic [NUM_SCORES-1:0][SCORE_W-1:0]    lat_q;
    logic [NUM_SCORES-1:0][BW-1:0]         shadow_q, disp_q;
    logic                                  conv_busy, conv_done, conv_ovf;
    logic [BW-1:0]                         conv_bcd;
    logic                                  endframe;
    logic [PXS_W-1:0]                      s1_q, out_q;
    logic [NUM_SCORES-1:0]                 hit_d, hit_q;
    logic [NUM_SCORES-1:0][3:0]            dig_d, dig_q;
    logic [NUM_SCORES-1:0][2:0]            row_d, row_q, col_d, col_q;
    logic [2:0]                            rgb_d;
    int                                    ox, oy;
    logic                                  lz;

    assign endframe = RGBStr_i[XC_LO +: 10] == 10'(VISIBLECOLS - 1) &&
                      RGBStr_i[YC_LO +: 10] == 10'(VISIBLEROWS - 1);

    pxs_bin2bcd #(.BIN_W(SCORE_W), .DIGITS(DIGITS)) u_bcd (
        .clk     (px_clk),
        .rst_n   (rst_n),
        .start_i (start_q),
        .bin_i   (lat_q[idx_q]),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd),
        .ovf_o   (conv_ovf)
    );

    // Conversions land in the shadow; the display only changes in COMMIT, during vblank.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            start_q  <= 1'b0;
            upd_q    <= 1'b0;
            lat_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
        end else begin
            start_q <= 1'b0;
            upd_q   <= 1'b0;
            case (state_q)
                ST_IDLE: if (endframe) state_q <= ST_LOAD;
                ST_LOAD: if (!conv_busy) begin
                    lat_q   <= scores;
                    idx_q   <= '0;
                    start_q <= 1'b1;
                    state_q <= ST_CONV;
                end
                ST_CONV: if (conv_done) begin
                    shadow_q[idx_q] <= conv_ovf ? {DIGITS{4'd9}} : conv_bcd;
                    if (idx_q == IW'(NUM_SCORES - 1)) state_q <= ST_COMMIT;
                    else begin
                        idx_q   <= idx_q + 1'b1;
                        start_q <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    disp_q  <= shadow_q;
                    upd_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stage 1: locate the pixel inside each field's digit cells. lz tracks the run of leading
    // zeros from the most significant digit; the rightmost cell is never blanked.
    always_comb begin
        hit_d = '0;
        dig_d = '0;
        row_d = '0;
        col_d = '0;
        ox    = 0;
        oy    = 0;
        lz    = 1'b0;
        for (int k = 0; k < NUM_SCORES; k++) begin
            ox       = int'(RGBStr_i[XC_LO +: 10]) - int'(POS_X[10*k +: 10]);
            oy       = int'(RGBStr_i[YC_LO +: 10]) - int'(POS_Y[10*k +: 10]);
            lz       = BLANK_LZ;
            row_d[k] = 3'(oy >> SCALE_LOG2);
            for (int d = 0; d < DIGITS; d++) begin
                lz = lz && disp_q[k][BW-4-4*d +: 4] == 4'd0 && d != DIGITS - 1;
                if (oy >= 0 && oy < CELL && ox >= d*PITCH && ox < d*PITCH + CELL && !lz) begin
                    hit_d[k] = 1'b1;
                    dig_d[k] = disp_q[k][BW-4-4*d +: 4];
                    col_d[k] = 3'((ox - d*PITCH) >> SCALE_LOG2);
                end
            end
        end
    end

    // Stage 2: scanning from the highest index down lets the lowest lit field win overlaps.
    always_comb begin
        rgb_d = s1_q[RGB_LO +: 3];
        for (int k = NUM_SCORES - 1; k >= 0; k--)
            if (s1_q[ACT_B] && hit_q[k] && glyph_bit(dig_q[k], row_q[k], col_q[k])) rgb_d = INK[3*k +: 3];
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            hit_q <= '0;
            dig_q <= '0;
            row_q <= '0;
            col_q <= '0;
            out_q <= '0;
        end else begin
            s1_q  <= RGBStr_i;
            hit_q <= hit_d;
            dig_q <= dig_d;
            row_q <= row_d;
            col_q <= col_d;
            out_q <= {s1_q[PXS_W-1:RGB_LO+3], rgb_d, s1_q[RGB_LO-1:0]};
        end
    end

    assign RGBStr_o      = out_q;
    assign score_updated = upd_q;
endmodule

// File: tb/tb_pxs_score_overlay_multi.sv
// tb_pxs_score_overlay_multi: directed + randomized pixel checks of the score overlay against a decimal model.
module tb_pxs_score_overlay_multi;
    localparam int N = 2, SW = 10, DG = 3, SL = 1, CELL = 8 << SL, P = CELL + 4;
    localparam int PX0 = 100, PX1 = 140, PY = 32;
    localparam logic [2:0] INK0 = 3'b101, INK1 = 3'b010, BG = 3'b111;
    localparam int BOUND = N * (SW + 3) + 3;

    logic          px_clk = 1'b0;
    logic          rst_n  = 1'b0;
    logic [N*SW-1:0] scores = '0;
    logic [25:0]   sin = '0;
    logic [25:0]   sout;
    logic          upd;
    int            disp[N];
    int            n_chk = 0, n_pass = 0;

    pxs_score_overlay_multi #(
        .NUM_SCORES(N), .SCORE_W(SW), .DIGITS(DG), .SCALE_LOG2(SL), .DIGIT_GAP(4),
        .POS_X({10'd140, 10'd100}), .POS_Y({10'd32, 10'd32}), .INK({INK1, INK0}), .BLANK_LZ(1'b1)
    ) dut (
        .px_clk        (px_clk),
        .rst_n         (rst_n),
        .scores        (scores),
        .RGBStr_i      (sin),
        .RGBStr_o      (sout),
        .score_updated (upd)
    );

    always #5 px_clk = ~px_clk;

    function automatic logic fbit(int dg, int r, int c);
        logic [63:0] g;
        case (dg)
            0: g = 64'h3C666E7666663C00;
            1: g = 64'h1838181818187E00;
            2: g = 64'h3C66060C30607E00;
            3: g = 64'h3C66061C06663C00;
            4: g = 64'h0C1C3C6C7E0C0C00;
            5: g = 64'h7E607C0606663C00;
            6: g = 64'h3C607C6666663C00;
            7: g = 64'h7E060C1830303000;
            8: g = 64'h3C66663C66663C00;
            9: g = 64'h3C66663E060C3800;
            default: g = '0;
        endcase
        return g[63 - 8*r - c];
    endfunction

    // Decimal view of each field: saturate, pick the digit by power of ten, blank leading zeros.
    function automatic logic [2:0] exp_rgb(int x, int y, logic act, logic [2:0] rgb);
        for (int k = 0; k < N; k++) begin
            int v;
            v = disp[k] > 999 ? 999 : disp[k];
            for (int d = 0; d < DG; d++) begin
                int cx, pw;
                cx = (k == 0 ? PX0 : PX1) + d * P;
                pw = 10 ** (DG - 1 - d);
                if (act && x >= cx && x < cx + CELL && y >= PY && y < PY + CELL &&
                    (d == DG - 1 || v >= pw) && fbit((v / pw) % 10, (y - PY) / 2, (x - cx) / 2))
                    return k == 0 ? INK0 : INK1;
            end
        end
        return rgb;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pix(string tag, int x, int y, logic act, logic [2:0] rgb, logic hs, logic vs);
        logic [25:0] e;
        e   = {hs, vs, act, exp_rgb(x, y, act, rgb), 10'(x), 10'(y)};
        sin = {hs, vs, act, rgb, 10'(x), 10'(y)};
        @(posedge px_clk);
        @(posedge px_clk);
        #1;
        chk(tag, 32'(sout), 32'(e));
    endtask

    task automatic dpix(string tag, int x, int y, logic [2:0] want);
        sin = {3'b001, BG, 10'(x), 10'(y)};
        @(posedge px_clk);
        @(posedge px_clk);
        #1;
        chk(tag, 32'(sout), 32'({3'b001, want, 10'(x), 10'(y)}));
    endtask

    task automatic rand_pix(string tag, int n);
        for (int i = 0; i < n; i++) begin
            int x, y;
            if ($urandom_range(3) != 0) begin
                x = $urandom_range(210, 90);
                y = $urandom_range(52, 26);
            end else begin
                x = $urandom_range(639);
                y = $urandom_range(470);
            end
            pix(tag, x, y, $urandom_range(7) != 0, 3'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic endframe_pulse();
        sin = {3'b000, 3'd0, 10'd639, 10'd479};
        @(posedge px_clk);
        #1;
        sin = '0;
    endtask

    task automatic frame(string tag);
        int pend[N];
        int first, pulses;
        first  = -1;
        pulses = 0;
        for (int k = 0; k < N; k++) pend[k] = int'(scores[k*SW +: SW]);
        endframe_pulse();
        for (int i = 1; i <= 60; i++) begin
            @(posedge px_clk);
            #1;
            if (upd) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        chk({tag, " pulses"}, 32'(pulses), 32'(1));
        chk({tag, " in time"}, 32'(first >= 1 && first <= BOUND), 32'(1));
        disp = pend;
    endtask

    initial begin
        int pulses;
        disp = '{0, 0};
        for (int i = 0; i < 3; i++) begin
            sin = {3'($urandom), 3'($urandom), 10'd144, 10'd32};
            @(posedge px_clk);
            @(posedge px_clk);
            #1;
            chk("reset out", 32'(sout), 32'(0));
        end
        chk("reset upd", 32'(upd), 32'(0));
        rst_n = 1'b1;
        sin = {3'b001, 3'd3, 10'd10, 10'd10};
        repeat (3) @(posedge px_clk);
        #1;
        sin = {3'b001, 3'd5, 10'd20, 10'd10};
        @(posedge px_clk);
        #1;
        chk("latency 1", 32'(sout), 32'({3'b001, 3'd3, 10'd10, 10'd10}));
        @(posedge px_clk);
        #1;
        chk("latency 2", 32'(sout), 32'({3'b001, 3'd5, 10'd20, 10'd10}));
        dpix("zero f0", 144, 32, INK0);
        dpix("zero f1", 184, 32, INK1);
        dpix("zero lz", 104, 32, BG);
        dpix("zero gap", 156, 32, BG);
        rand_pix("zero rand", 30);

        scores = {10'd7, 10'd255};
        frame("f255/7");
        dpix("255 d0", 104, 32, INK0);
        dpix("255 d2", 144, 32, INK0);
        dpix("7 d2", 182, 32, INK1);
        dpix("7 lz", 164, 32, BG);
        rand_pix("255/7 rand", 60);

        scores = {10'd150, 10'd1023};
        frame("fsat");
        dpix("sat 9", 104, 32, INK0);
        dpix("150 under 9", 142, 44, INK1);
        dpix("overlap 9", 144, 44, INK0);
        rand_pix("sat rand", 60);

        scores = '0;
        rand_pix("no tear", 40);
        frame("fzero");
        rand_pix("zero again", 20);

        scores = {10'd888, 10'd880};
        frame("fovl");
        dpix("ovl both", 144, 38, INK0);
        dpix("ovl f1 only", 148, 38, INK1);
        dpix("ovl gap", 156, 32, BG);
        rand_pix("ovl rand", 40);

        scores = {10'd7, 10'd255};
        endframe_pulse();
        repeat (6) @(posedge px_clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("mid rst out", 32'(sout), 32'(0));
        @(posedge px_clk);
        #1;
        rst_n = 1'b1;
        disp = '{0, 0};
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge px_clk);
            #1;
            if (upd) pulses++;
        end
        chk("mid rst no upd", 32'(pulses), 32'(0));
        dpix("mid rst zero", 144, 32, INK0);
        rand_pix("mid rst rand", 20);
        frame("f after rst");
        rand_pix("after rst rand", 30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
